rot_coord_gen: RTL

Sequential rotated-coordinate generator for the descriptor stage. It replaces the per-orientation distributed ROMs with one parametrised engine. On a start pulse it scans a WIN×WIN sample window in row-major order. For each sample it streams the window position rotated by orientation index k, rounded and saturated, through a valid/ready output. It sits between the orientation-assignment stage and the histogram-binning stage.

---
 rtl/rot_coord_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/rot_coord_gen.sv
// Rotated-coordinate generator: scans a WIN x WIN window row-major and streams each
// position rotated by orientation dir, rounded and saturated, through a 3-stage pipeline.
module rot_coord_gen #(
    parameter  int NDIR  = 36,
    parameter  int WIN   = 16,
    parameter  int FRAC  = 8,
    parameter  int OUT_W = 5,
    parameter  int OFS   = 0,
    localparam int DIR_W = (NDIR > 1) ? $clog2(NDIR) : 1,
    localparam int POS_W = (WIN > 1) ? $clog2(WIN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIR_W-1:0]        dir,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_x,
    output logic signed [OUT_W-1:0] out_y,
    output logic [POS_W-1:0]        out_row,
    output logic [POS_W-1:0]        out_col,
    output logic                    out_sat,
    output logic                    out_last,
    output logic [1:0]              dbg_state_o
);
    localparam int C_W = FRAC + 2;
    localparam int U_W = POS_W + 2;
    localparam int P_W = U_W + C_W;
    localparam int S_W = P_W + 2;
    localparam logic signed [S_W-1:0] HALF = S_W'(1 << FRAC);
    localparam logic signed [S_W-1:0] MAXV = S_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [S_W-1:0] MINV = S_W'(-(1 << (OUT_W - 1)));

    typedef logic signed [C_W-1:0] trig_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

    trig_t cos_rom [NDIR];
    trig_t sin_rom [NDIR];

    for (genvar k = 0; k < NDIR; k++) begin : g_rom
        localparam real ANG = 6.283185307179586 * k / NDIR;
        localparam real CR  = $cos(ANG) * real'(1 << FRAC);
        localparam real SR  = $sin(ANG) * real'(1 << FRAC);
        localparam int  CI  = $rtoi((CR < 0.0) ? CR - 0.5 : CR + 0.5);
        localparam int  SI  = $rtoi((SR < 0.0) ? SR - 0.5 : SR + 0.5);
        assign cos_rom[k] = C_W'(CI);
        assign sin_rom[k] = C_W'(SI);
    end

    // Handshake: a beat transfers on a rising edge where out_valid && out_ready; while
    // out_valid && !out_ready every stage and the address counter hold their contents.
    state_t state_q, state_d;
    logic   advance, issue, at_end, last_acc;

    logic [POS_W-1:0] row_q, col_q;
    logic [DIR_W-1:0] dir_q;

    logic                    v1_q, last1_q;
    trig_t                   c1_q, s1_q;
    logic signed [U_W-1:0]   u1_q, w1_q, u_d, w_d;
    logic [POS_W-1:0]        row1_q, col1_q;

    logic                    v2_q, last2_q;
    logic signed [P_W-1:0]   uc2_q, us2_q, wc2_q, ws2_q;
    logic [POS_W-1:0]        row2_q, col2_q;

    logic                    v3_q, last3_q, sat3_q;
    logic signed [OUT_W-1:0] x3_q, y3_q;
    logic [POS_W-1:0]        row3_q, col3_q;

    logic signed [S_W-1:0]   xr, yr, xo, yo;
    logic [OUT_W:0]          xsat, ysat;

    assign advance  = !(v3_q && !out_ready);
    assign at_end   = (row_q == POS_W'(WIN - 1)) && (col_q == POS_W'(WIN - 1));
    assign last_acc = v3_q && last3_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (issue && at_end) state_d = S_DRAIN;
            S_DRAIN: if (last_acc) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        issue       = (state_q == S_RUN) && advance;
        dbg_state_o = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            dir_q <= '0;
        end else begin
            if (state_q == S_IDLE && start) dir_q <= (int'(dir) >= NDIR) ? '0 : dir;
            if (issue) begin
                if (col_q == POS_W'(WIN - 1)) begin
                    col_q <= '0;
                    row_q <= at_end ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // Doubled, centred coordinates keep the half-sample window centre exact.
    always_comb begin
        u_d = U_W'(2 * int'(col_q) - (WIN - 1));
        w_d = U_W'(2 * int'(row_q) - (WIN - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0; last1_q <= 1'b0; c1_q <= '0; s1_q <= '0;
            u1_q <= '0; w1_q <= '0; row1_q <= '0; col1_q <= '0;
        end else if (advance) begin
            v1_q <= issue;
            if (issue) begin
                c1_q    <= cos_rom[dir_q];
                s1_q    <= sin_rom[dir_q];
                u1_q    <= u_d;
                w1_q    <= w_d;
                row1_q  <= row_q;
                col1_q  <= col_q;
                last1_q <= at_end;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0; last2_q <= 1'b0; uc2_q <= '0; us2_q <= '0;
            wc2_q <= '0; ws2_q <= '0; row2_q <= '0; col2_q <= '0;
        end else if (advance) begin
            v2_q <= v1_q;
            if (v1_q) begin
                uc2_q   <= P_W'(u1_q) * P_W'(c1_q);
                us2_q   <= P_W'(u1_q) * P_W'(s1_q);
                wc2_q   <= P_W'(w1_q) * P_W'(c1_q);
                ws2_q   <= P_W'(w1_q) * P_W'(s1_q);
                row2_q  <= row1_q;
                col2_q  <= col1_q;
                last2_q <= last1_q;
            end
        end
    end

    function automatic logic [OUT_W:0] sat_fn(input logic signed [S_W-1:0] a);
        if (a > MAXV)      return {1'b1, MAXV[OUT_W-1:0]};
        else if (a < MINV) return {1'b1, MINV[OUT_W-1:0]};
        else               return {1'b0, a[OUT_W-1:0]};
    endfunction

    // Adding 2^FRAC then shifting by FRAC+1 undoes both the doubling and the trig scale.
    always_comb begin
        xr   = S_W'(uc2_q) - S_W'(ws2_q);
        yr   = S_W'(us2_q) + S_W'(wc2_q);
        xo   = ((xr + HALF) >>> (FRAC + 1)) + S_W'(OFS);
        yo   = ((yr + HALF) >>> (FRAC + 1)) + S_W'(OFS);
        xsat = sat_fn(xo);
        ysat = sat_fn(yo);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q <= 1'b0; last3_q <= 1'b0; sat3_q <= 1'b0;
            x3_q <= '0; y3_q <= '0; row3_q <= '0; col3_q <= '0;
        end else if (advance) begin
            v3_q <= v2_q;
            if (v2_q) begin
                x3_q    <= xsat[OUT_W-1:0];
                y3_q    <= ysat[OUT_W-1:0];
                sat3_q  <= xsat[OUT_W] | ysat[OUT_W];
                row3_q  <= row2_q;
                col3_q  <= col2_q;
                last3_q <= last2_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign out_x     = x3_q;
    assign out_y     = y3_q;
    assign out_row   = row3_q;
    assign out_col   = col3_q;
    assign out_sat   = sat3_q;
    assign out_last  = last3_q;
endmodule
